// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared constants, the packed dispatch bundle and the
// writeback wakeup-match helper used by the dispatch stage and its busy table.
package dispatch_pkg;

  localparam int PREG_NUM     = 64;
  localparam int PREG_W       = 6;
  localparam int ROB_SIZE_LOG = 6;
  localparam int PAYLOAD_W    = 160;

  // One renamed instruction as held in the dispatch slot.
  typedef struct packed {
    logic [PAYLOAD_W-1:0]    payload;
    logic [PREG_W-1:0]       prs1;
    logic [PREG_W-1:0]       prs2;
    logic [PREG_W-1:0]       prd;
    logic                    src1_is_reg;
    logic                    src2_is_reg;
    logic                    need_to_wb;
    logic                    robidx_flag;
    logic [ROB_SIZE_LOG-1:0] robidx;
  } disp_bundle_t;

  // True when either writeback port wakes up physical register preg.
  function automatic logic wakeup_hit(
    input logic              wb0_valid,
    input logic              wb0_need_to_wb,
    input logic [PREG_W-1:0] wb0_prd,
    input logic              wb1_valid,
    input logic              wb1_need_to_wb,
    input logic [PREG_W-1:0] wb1_prd,
    input logic [PREG_W-1:0] preg
  );
    return (wb0_valid & wb0_need_to_wb & (wb0_prd == preg)) |
           (wb1_valid & wb1_need_to_wb & (wb1_prd == preg));
  endfunction

endpackage

// File: rtl/dispatch_stage_busy_table.sv
// dispatch_stage_busy_table: one busy bit per physical register.
// Ports:
//   clock, reset_n            clock, async active-low reset
//   set_valid/set_prd         mark a newly allocated destination busy
//   wb0_*, wb1_*              writeback wakeups (clear busy)
//   walk_valid/walk_prd       post-flush rollback (clear busy)
//   rd0_prs/rd0_busy,
//   rd1_prs/rd1_busy          combinational lookups with same-cycle wakeup bypass
module dispatch_stage_busy_table
  import dispatch_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              set_valid,
  input  logic [PREG_W-1:0] set_prd,
  input  logic              wb0_valid,
  input  logic              wb0_need_to_wb,
  input  logic [PREG_W-1:0] wb0_prd,
  input  logic              wb1_valid,
  input  logic              wb1_need_to_wb,
  input  logic [PREG_W-1:0] wb1_prd,
  input  logic              walk_valid,
  input  logic [PREG_W-1:0] walk_prd,
  input  logic [PREG_W-1:0] rd0_prs,
  output logic              rd0_busy,
  input  logic [PREG_W-1:0] rd1_prs,
  output logic              rd1_busy
);

  logic [PREG_NUM-1:0] busy_q;
  logic [PREG_NUM-1:0] busy_d;

  // Next busy vector: allocation beats a same-cycle clear; preg 0 is never busy.
  always_comb begin
    busy_d = busy_q;
    busy_d[0] = 1'b0;
    for (int unsigned p = 32'd1; p < PREG_NUM; p++) begin
      if (set_valid && (set_prd == PREG_W'(p))) begin
        busy_d[p] = 1'b1;
      end else if (wakeup_hit(wb0_valid, wb0_need_to_wb, wb0_prd,
                              wb1_valid, wb1_need_to_wb, wb1_prd, PREG_W'(p)) ||
                   (walk_valid && (walk_prd == PREG_W'(p)))) begin
        busy_d[p] = 1'b0;
      end else begin
        busy_d[p] = busy_q[p];
      end
    end
  end

  // Busy table register, cleared asynchronously on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= {PREG_NUM{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // A wakeup in the lookup cycle already counts as ready (bypass).
  assign rd0_busy = busy_q[rd0_prs] & (rd0_prs != {PREG_W{1'b0}}) &
                    ~wakeup_hit(wb0_valid, wb0_need_to_wb, wb0_prd,
                                wb1_valid, wb1_need_to_wb, wb1_prd, rd0_prs);
  assign rd1_busy = busy_q[rd1_prs] & (rd1_prs != {PREG_W{1'b0}}) &
                    ~wakeup_hit(wb0_valid, wb0_need_to_wb, wb0_prd,
                                wb1_valid, wb1_need_to_wb, wb1_prd, rd1_prs);

endmodule

// File: rtl/dispatch_stage.sv
// dispatch_stage: single-entry slot between rename and the integer issue queue.
// Ports:
//   clock, reset_n        clock, async active-low reset
//   rn_*                  renamed instruction in, rn_valid/rn_ready handshake
//   iq_*                  registered instruction out, iq_valid/iq_ready handshake,
//                         iq_src1/2_state = 1 while the operand is still busy
//   writeback0/1_*        wakeup ports
//   flush_valid           redirect pulse, squashes the slot
//   walk_valid/walk_prd   rollback frees the busy bit of a squashed destination
module dispatch_stage
  import dispatch_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    rn_valid,
  output logic                    rn_ready,
  input  logic [PAYLOAD_W-1:0]    rn_payload,
  input  logic [PREG_W-1:0]       rn_prs1,
  input  logic [PREG_W-1:0]       rn_prs2,
  input  logic [PREG_W-1:0]       rn_prd,
  input  logic                    rn_src1_is_reg,
  input  logic                    rn_src2_is_reg,
  input  logic                    rn_need_to_wb,
  input  logic                    rn_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] rn_robidx,
  output logic                    iq_valid,
  input  logic                    iq_ready,
  output logic [PAYLOAD_W-1:0]    iq_payload,
  output logic [PREG_W-1:0]       iq_prs1,
  output logic [PREG_W-1:0]       iq_prs2,
  output logic [PREG_W-1:0]       iq_prd,
  output logic                    iq_src1_is_reg,
  output logic                    iq_src2_is_reg,
  output logic                    iq_need_to_wb,
  output logic                    iq_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] iq_robidx,
  output logic                    iq_src1_state,
  output logic                    iq_src2_state,
  input  logic                    writeback0_valid,
  input  logic                    writeback0_need_to_wb,
  input  logic [PREG_W-1:0]       writeback0_prd,
  input  logic                    writeback1_valid,
  input  logic                    writeback1_need_to_wb,
  input  logic [PREG_W-1:0]       writeback1_prd,
  input  logic                    flush_valid,
  input  logic                    walk_valid,
  input  logic [PREG_W-1:0]       walk_prd
);

  disp_bundle_t rn_bundle;
  disp_bundle_t slot_q, slot_d;
  logic         slot_valid_q, slot_valid_d;
  logic         src1_state_q, src1_state_d;
  logic         src2_state_q, src2_state_d;
  logic         fire;
  logic         src1_busy, src2_busy;

  assign rn_bundle = '{payload:     rn_payload,
                       prs1:        rn_prs1,
                       prs2:        rn_prs2,
                       prd:         rn_prd,
                       src1_is_reg: rn_src1_is_reg,
                       src2_is_reg: rn_src2_is_reg,
                       need_to_wb:  rn_need_to_wb,
                       robidx_flag: rn_robidx_flag,
                       robidx:      rn_robidx};

  // Rename stalls during redirect and rollback so no flushed work enters.
  assign rn_ready = (~slot_valid_q | iq_ready) & ~flush_valid & ~walk_valid;
  assign fire     = rn_valid & rn_ready;
  // The issue queue does not arbitrate flush against enqueue, so mask here.
  assign iq_valid = slot_valid_q & ~flush_valid;

  dispatch_stage_busy_table u_busy_table (
    .clock          (clock),
    .reset_n        (reset_n),
    .set_valid      (fire & rn_need_to_wb),
    .set_prd        (rn_prd),
    .wb0_valid      (writeback0_valid),
    .wb0_need_to_wb (writeback0_need_to_wb),
    .wb0_prd        (writeback0_prd),
    .wb1_valid      (writeback1_valid),
    .wb1_need_to_wb (writeback1_need_to_wb),
    .wb1_prd        (writeback1_prd),
    .walk_valid     (walk_valid),
    .walk_prd       (walk_prd),
    .rd0_prs        (rn_prs1),
    .rd0_busy       (src1_busy),
    .rd1_prs        (rn_prs2),
    .rd1_busy       (src2_busy)
  );

  // Slot next state: flush > fire > drain > hold; held state bits still see wakeups.
  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    src1_state_d = src1_state_q & ~wakeup_hit(writeback0_valid, writeback0_need_to_wb,
                                              writeback0_prd, writeback1_valid,
                                              writeback1_need_to_wb, writeback1_prd,
                                              slot_q.prs1);
    src2_state_d = src2_state_q & ~wakeup_hit(writeback0_valid, writeback0_need_to_wb,
                                              writeback0_prd, writeback1_valid,
                                              writeback1_need_to_wb, writeback1_prd,
                                              slot_q.prs2);
    if (flush_valid) begin
      slot_valid_d = 1'b0;
    end else if (fire) begin
      slot_valid_d = 1'b1;
      slot_d       = rn_bundle;
      src1_state_d = rn_src1_is_reg & src1_busy;
      src2_state_d = rn_src2_is_reg & src2_busy;
    end else if (iq_ready) begin
      slot_valid_d = 1'b0;
    end else begin
      slot_valid_d = slot_valid_q;
    end
  end

  // Slot registers, cleared asynchronously on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
      src1_state_q <= 1'b0;
      src2_state_q <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_q       <= slot_d;
      src1_state_q <= src1_state_d;
      src2_state_q <= src2_state_d;
    end
  end

  assign iq_payload     = slot_q.payload;
  assign iq_prs1        = slot_q.prs1;
  assign iq_prs2        = slot_q.prs2;
  assign iq_prd         = slot_q.prd;
  assign iq_src1_is_reg = slot_q.src1_is_reg;
  assign iq_src2_is_reg = slot_q.src2_is_reg;
  assign iq_need_to_wb  = slot_q.need_to_wb;
  assign iq_robidx_flag = slot_q.robidx_flag;
  assign iq_robidx      = slot_q.robidx;
  assign iq_src1_state  = src1_state_q;
  assign iq_src2_state  = src2_state_q;

endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: table-driven capture vectors, hand-written corner
// sequences and a randomized run, all checked against a queue/associative
// array reference model of the dispatch slot and busy table.
`timescale 1ns/1ps
module tb_dispatch_stage;
  import dispatch_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic                    rn_valid, rn_ready;
  logic [PAYLOAD_W-1:0]    rn_payload;
  logic [PREG_W-1:0]       rn_prs1, rn_prs2, rn_prd;
  logic                    rn_src1_is_reg, rn_src2_is_reg, rn_need_to_wb, rn_robidx_flag;
  logic [ROB_SIZE_LOG-1:0] rn_robidx;
  logic                    iq_valid, iq_ready;
  logic [PAYLOAD_W-1:0]    iq_payload;
  logic [PREG_W-1:0]       iq_prs1, iq_prs2, iq_prd;
  logic                    iq_src1_is_reg, iq_src2_is_reg, iq_need_to_wb, iq_robidx_flag;
  logic [ROB_SIZE_LOG-1:0] iq_robidx;
  logic                    iq_src1_state, iq_src2_state;
  logic                    writeback0_valid, writeback0_need_to_wb;
  logic [PREG_W-1:0]       writeback0_prd;
  logic                    writeback1_valid, writeback1_need_to_wb;
  logic [PREG_W-1:0]       writeback1_prd;
  logic                    flush_valid, walk_valid;
  logic [PREG_W-1:0]       walk_prd;

  dispatch_stage dut (
    .clock(clock), .reset_n(reset_n),
    .rn_valid(rn_valid), .rn_ready(rn_ready), .rn_payload(rn_payload),
    .rn_prs1(rn_prs1), .rn_prs2(rn_prs2), .rn_prd(rn_prd),
    .rn_src1_is_reg(rn_src1_is_reg), .rn_src2_is_reg(rn_src2_is_reg),
    .rn_need_to_wb(rn_need_to_wb), .rn_robidx_flag(rn_robidx_flag), .rn_robidx(rn_robidx),
    .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_payload(iq_payload),
    .iq_prs1(iq_prs1), .iq_prs2(iq_prs2), .iq_prd(iq_prd),
    .iq_src1_is_reg(iq_src1_is_reg), .iq_src2_is_reg(iq_src2_is_reg),
    .iq_need_to_wb(iq_need_to_wb), .iq_robidx_flag(iq_robidx_flag), .iq_robidx(iq_robidx),
    .iq_src1_state(iq_src1_state), .iq_src2_state(iq_src2_state),
    .writeback0_valid(writeback0_valid), .writeback0_need_to_wb(writeback0_need_to_wb),
    .writeback0_prd(writeback0_prd),
    .writeback1_valid(writeback1_valid), .writeback1_need_to_wb(writeback1_need_to_wb),
    .writeback1_prd(writeback1_prd),
    .flush_valid(flush_valid), .walk_valid(walk_valid), .walk_prd(walk_prd)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: the slot is a queue of at most one entry, the busy
  // table is the set of busy pregs.
  typedef struct {
    logic [PAYLOAD_W-1:0]    payload;
    logic [PREG_W-1:0]       prs1, prs2, prd;
    logic                    r1, r2, nwb, rf;
    logic [ROB_SIZE_LOG-1:0] ri;
    logic                    s1, s2;
  } mentry_t;
  mentry_t mslot[$];
  bit      mbusy[int];

  typedef struct {
    logic [PREG_W-1:0] prs1; logic r1;
    logic [PREG_W-1:0] prs2; logic r2;
    logic w0v, w0n; logic [PREG_W-1:0] w0p;
    logic w1v, w1n; logic [PREG_W-1:0] w1p;
    logic e1, e2;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_hit(input int p);
    return (writeback0_valid && writeback0_need_to_wb && int'(writeback0_prd) == p) ||
           (writeback1_valid && writeback1_need_to_wb && int'(writeback1_prd) == p);
  endfunction

  function automatic logic [PAYLOAD_W-1:0] rnd_payload();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_model();
    bit occ;
    bit exp_rdy;
    occ = (mslot.size() != 0);
    exp_rdy = (!occ || iq_ready) && !flush_valid && !walk_valid;
    chk("rn_ready", 256'(rn_ready), 256'(exp_rdy));
    chk("iq_valid", 256'(iq_valid), 256'(occ && !flush_valid));
    if (occ) begin
      chk("slot", 256'({iq_payload, iq_prs1, iq_prs2, iq_prd, iq_src1_is_reg, iq_src2_is_reg,
                        iq_need_to_wb, iq_robidx_flag, iq_robidx, iq_src1_state, iq_src2_state}),
                  256'({mslot[0].payload, mslot[0].prs1, mslot[0].prs2, mslot[0].prd,
                        mslot[0].r1, mslot[0].r2, mslot[0].nwb, mslot[0].rf, mslot[0].ri,
                        mslot[0].s1, mslot[0].s2}));
    end
  endtask

  task automatic model_step();
    bit occ, rdy, fire;
    mentry_t e;
    occ  = (mslot.size() != 0);
    rdy  = (!occ || iq_ready) && !flush_valid && !walk_valid;
    fire = rn_valid && rdy;
    if (fire) begin
      e.payload = rn_payload; e.prs1 = rn_prs1; e.prs2 = rn_prs2; e.prd = rn_prd;
      e.r1 = rn_src1_is_reg; e.r2 = rn_src2_is_reg; e.nwb = rn_need_to_wb;
      e.rf = rn_robidx_flag; e.ri = rn_robidx;
      e.s1 = rn_src1_is_reg && mbusy.exists(int'(rn_prs1)) && !m_hit(int'(rn_prs1));
      e.s2 = rn_src2_is_reg && mbusy.exists(int'(rn_prs2)) && !m_hit(int'(rn_prs2));
    end
    if (occ && !fire) begin
      e = mslot[0];
      if (m_hit(int'(e.prs1))) e.s1 = 1'b0;
      if (m_hit(int'(e.prs2))) e.s2 = 1'b0;
    end
    // Clears first, then allocation, so allocation wins.
    if (writeback0_valid && writeback0_need_to_wb) mbusy.delete(int'(writeback0_prd));
    if (writeback1_valid && writeback1_need_to_wb) mbusy.delete(int'(writeback1_prd));
    if (walk_valid) mbusy.delete(int'(walk_prd));
    if (fire && rn_need_to_wb && rn_prd != 6'd0) mbusy[int'(rn_prd)] = 1'b1;
    if (flush_valid) mslot.delete();
    else if (fire) begin mslot.delete(); mslot.push_back(e); end
    else if (iq_ready) mslot.delete();
    else if (occ) mslot[0] = e;
  endtask

  task automatic tick();
    @(negedge clock);
    check_model();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle();
    rn_valid = 1'b0; iq_ready = 1'b1; flush_valid = 1'b0; walk_valid = 1'b0;
    walk_prd = 6'd0;
    writeback0_valid = 1'b0; writeback0_need_to_wb = 1'b0; writeback0_prd = 6'd0;
    writeback1_valid = 1'b0; writeback1_need_to_wb = 1'b0; writeback1_prd = 6'd0;
  endtask

  task automatic drive_rn(input logic [PAYLOAD_W-1:0] pl, input logic [PREG_W-1:0] p1,
                          input logic r1, input logic [PREG_W-1:0] p2, input logic r2,
                          input logic [PREG_W-1:0] pd, input logic nwb);
    rn_valid = 1'b1; rn_payload = pl; rn_prs1 = p1; rn_src1_is_reg = r1;
    rn_prs2 = p2; rn_src2_is_reg = r2; rn_prd = pd; rn_need_to_wb = nwb;
    rn_robidx_flag = 1'($urandom()); rn_robidx = ROB_SIZE_LOG'($urandom());
  endtask

  task automatic check_cleared(input string name);
    chk({name, "_valid"}, 256'(iq_valid), 256'(1'b0));
    chk({name, "_data"}, 256'({iq_payload, iq_prs1, iq_prs2, iq_prd, iq_src1_is_reg,
                               iq_src2_is_reg, iq_need_to_wb, iq_robidx_flag, iq_robidx,
                               iq_src1_state, iq_src2_state}), 256'(0));
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  logic [PAYLOAD_W-1:0] pa, pb;

  initial begin
    vecs[0] = '{6'd30, 1'b1, 6'd31, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b1, 1'b1};
    vecs[1] = '{6'd30, 1'b0, 6'd31, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 1'b1};
    vecs[2] = '{6'd5,  1'b1, 6'd0,  1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 1'b0};
    vecs[3] = '{6'd30, 1'b1, 6'd31, 1'b1, 1'b1, 1'b0, 6'd30, 1'b0, 1'b0, 6'd0,  1'b1, 1'b1};
    vecs[4] = '{6'd30, 1'b1, 6'd31, 1'b1, 1'b0, 1'b1, 6'd30, 1'b0, 1'b0, 6'd0,  1'b1, 1'b1};
    vecs[5] = '{6'd30, 1'b1, 6'd32, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 6'd32, 1'b1, 1'b0};
    vecs[6] = '{6'd32, 1'b1, 6'd31, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 1'b1};
    vecs[7] = '{6'd33, 1'b1, 6'd33, 1'b1, 1'b1, 1'b1, 6'd33, 1'b1, 1'b1, 6'd31, 1'b0, 1'b0};
    vecs[8] = '{6'd31, 1'b1, 6'd30, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 1'b1};

    reset_n = 1'b0;
    idle();
    drive_rn(160'd0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    rn_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_cleared("reset");
    release_reset();

    // First fire after reset: one-cycle latency, payload untouched, source ready.
    pa = rnd_payload();
    drive_rn(pa, 6'd5, 1'b1, 6'd0, 1'b0, 6'd40, 1'b1);
    tick();
    chk("first_valid", 256'(iq_valid), 256'(1'b1));
    chk("first_s1", 256'(iq_src1_state), 256'(1'b0));
    chk("first_payload", 256'(iq_payload), 256'(pa));

    // Table: producers 30..33, then consumers with assorted wakeups.
    for (int p = 30; p <= 33; p++) begin
      drive_rn(rnd_payload(), 6'd0, 1'b0, 6'd0, 1'b0, PREG_W'(p), 1'b1);
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      pa = rnd_payload();
      drive_rn(pa, vecs[i].prs1, vecs[i].r1, vecs[i].prs2, vecs[i].r2, 6'd0, 1'b0);
      writeback0_valid = vecs[i].w0v; writeback0_need_to_wb = vecs[i].w0n;
      writeback0_prd = vecs[i].w0p;
      writeback1_valid = vecs[i].w1v; writeback1_need_to_wb = vecs[i].w1n;
      writeback1_prd = vecs[i].w1p;
      tick();
      chk($sformatf("vec%0d_valid", i), 256'(iq_valid), 256'(1'b1));
      chk($sformatf("vec%0d_state", i), 256'({iq_src1_state, iq_src2_state}),
          256'({vecs[i].e1, vecs[i].e2}));
      chk($sformatf("vec%0d_payload", i), 256'(iq_payload), 256'(pa));
    end
    idle();
    tick();

    // Dependent pair, then wakeup of the held consumer.
    drive_rn(rnd_payload(), 6'd0, 1'b0, 6'd0, 1'b0, 6'd9, 1'b1);
    tick();
    pb = rnd_payload();
    drive_rn(pb, 6'd0, 1'b0, 6'd9, 1'b1, 6'd0, 1'b0);
    tick();
    chk("dep_s2_busy", 256'(iq_src2_state), 256'(1'b1));
    rn_valid = 1'b0; iq_ready = 1'b0;
    writeback0_valid = 1'b1; writeback0_need_to_wb = 1'b1; writeback0_prd = 6'd9;
    tick();
    chk("held_wake_s2", 256'(iq_src2_state), 256'(1'b0));
    chk("held_valid", 256'(iq_valid), 256'(1'b1));
    chk("held_payload", 256'(iq_payload), 256'(pb));
    idle();
    tick();

    // Same-cycle writeback bypass on port 1.
    drive_rn(rnd_payload(), 6'd0, 1'b0, 6'd0, 1'b0, 6'd12, 1'b1);
    tick();
    drive_rn(rnd_payload(), 6'd12, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
    writeback1_valid = 1'b1; writeback1_need_to_wb = 1'b1; writeback1_prd = 6'd12;
    tick();
    chk("bypass_s1", 256'(iq_src1_state), 256'(1'b0));
    idle();
    drive_rn(rnd_payload(), 6'd12, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
    tick();
    chk("after_bypass_s1", 256'(iq_src1_state), 256'(1'b0));
    idle();
    tick();

    // Stall three cycles, then drain and accept in the same cycle.
    pa = rnd_payload();
    drive_rn(pa, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b0);
    tick();
    pb = rnd_payload();
    drive_rn(pb, 6'd4, 1'b1, 6'd5, 1'b1, 6'd6, 1'b0);
    iq_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_rn_ready", 256'(rn_ready), 256'(1'b0));
      tick();
      chk("stall_payload", 256'(iq_payload), 256'(pa));
    end
    iq_ready = 1'b1;
    #1;
    chk("drain_rn_ready", 256'(rn_ready), 256'(1'b1));
    tick();
    chk("drain_new_payload", 256'(iq_payload), 256'(pb));
    idle();

    // Flush with a full slot, then a two-step walk.
    drive_rn(rnd_payload(), 6'd0, 1'b0, 6'd0, 1'b0, 6'd20, 1'b1);
    tick();
    drive_rn(rnd_payload(), 6'd0, 1'b0, 6'd0, 1'b0, 6'd21, 1'b1);
    tick();
    flush_valid = 1'b1;
    #1;
    chk("flush_iq_valid", 256'(iq_valid), 256'(1'b0));
    chk("flush_rn_ready", 256'(rn_ready), 256'(1'b0));
    tick();
    flush_valid = 1'b0;
    walk_valid = 1'b1; walk_prd = 6'd20;
    #1;
    chk("post_flush_empty", 256'(iq_valid), 256'(1'b0));
    chk("walk0_rn_ready", 256'(rn_ready), 256'(1'b0));
    tick();
    walk_prd = 6'd21;
    #1;
    chk("walk1_rn_ready", 256'(rn_ready), 256'(1'b0));
    tick();
    walk_valid = 1'b0;
    drive_rn(rnd_payload(), 6'd20, 1'b1, 6'd21, 1'b1, 6'd0, 1'b0);
    tick();
    chk("walk_freed", 256'({iq_src1_state, iq_src2_state}), 256'(2'b00));
    idle();

    // Preg 0 is never busy.
    drive_rn(rnd_payload(), 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    tick();
    drive_rn(rnd_payload(), 6'd0, 1'b1, 6'd0, 1'b1, 6'd0, 1'b0);
    tick();
    chk("preg0_state", 256'({iq_src1_state, iq_src2_state}), 256'(2'b00));
    idle();

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      drive_rn(rnd_payload(), PREG_W'($urandom_range(0, 7)), 1'($urandom()),
               PREG_W'($urandom_range(0, 7)), 1'($urandom()),
               PREG_W'($urandom_range(0, 7)), 1'($urandom()));
      rn_valid = ($urandom_range(0, 3) != 0);
      iq_ready = ($urandom_range(0, 3) != 0);
      flush_valid = ($urandom_range(0, 19) == 0);
      walk_valid = ($urandom_range(0, 9) == 0);
      walk_prd = PREG_W'($urandom_range(0, 7));
      writeback0_valid = 1'($urandom()); writeback0_need_to_wb = 1'($urandom());
      writeback0_prd = PREG_W'($urandom_range(0, 7));
      writeback1_valid = 1'($urandom()); writeback1_need_to_wb = 1'($urandom());
      writeback1_prd = PREG_W'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    // Reset in the middle of a stall: busy preg 40 must be freed too.
    drive_rn(rnd_payload(), 6'd0, 1'b0, 6'd0, 1'b0, 6'd40, 1'b1);
    tick();
    drive_rn(rnd_payload(), 6'd1, 1'b1, 6'd1, 1'b1, 6'd2, 1'b0);
    iq_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    idle();
    #1;
    check_cleared("midreset");
    mslot.delete();
    mbusy.delete();
    release_reset();
    drive_rn(rnd_payload(), 6'd40, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
    tick();
    chk("reset_busy_clear", 256'(iq_src1_state), 256'(1'b0));
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
